// File: rtl/reg16_ctrl_pkg.sv
// Shared types and constants for the 16-bit register load sequencer.
package reg16_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  localparam int HALF_W_DEF  = 8;
  localparam int NUM_REQ_DEF = 2;

  // The clear completion bit sits just above the per-requester done bits.
  function automatic int clr_done_idx(input int num_req);
    return num_req;
  endfunction

  localparam int CLR_DONE_IDX = clr_done_idx(NUM_REQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins,
// next_ptr points one past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      next_ptr
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg16_load_sequencer.sv
// Drives a byte-loaded 16-bit register: arbitrates full-width write requests,
// issues high-then-low byte loads, and serves a priority clear request.
module reg16_load_sequencer
  import reg16_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int HALF_W  = HALF_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*2*HALF_W-1:0] req_value,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        clr_valid,
  output logic                        clr_ready,
  output logic [NUM_REQ:0]            done,
  output logic                        busy,
  output logic [HALF_W-1:0]           halfvaluein,
  output logic                        loadhigh,
  output logic                        loadlow,
  output logic                        reg_clear_n
);

  localparam int VW      = 2 * HALF_W;
  localparam int PW      = $clog2(NUM_REQ);
  localparam int CLR_BIT = clr_done_idx(NUM_REQ);

  state_t              state, state_n;
  logic [PW-1:0]       ptr, ptr_n, idx_q, idx_n, gidx, arb_next;
  logic [VW-1:0]       val_q, val_n, sel_val;
  logic [NUM_REQ-1:0]  grant;
  logic [HALF_W-1:0]   half_n;
  logic [NUM_REQ:0]    done_n;
  logic                loadhigh_n, loadlow_n, clr_q, clr_n;
  logic                accept, arb_en;

  // Handshake: a requester is accepted on the edge where its valid and ready
  // are both high; ready never depends on the accepted value.
  assign accept    = (state == IDLE) || (state == LOAD_LO);
  assign clr_ready = accept && clr_valid;
  assign arb_en    = accept && !clr_valid;
  assign req_ready = grant;
  assign busy      = (state != IDLE);
  assign reg_clear_n = clr_q && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .en       (arb_en),
    .grant    (grant),
    .next_ptr (arb_next)
  );

  always_comb begin
    gidx    = '0;
    sel_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx    = PW'(i);
        sel_val = req_value[i*VW +: VW];
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    idx_n      = idx_q;
    val_n      = val_q;
    loadhigh_n = 1'b0;
    loadlow_n  = 1'b0;
    half_n     = halfvaluein;
    clr_n      = 1'b1;
    done_n     = '0;

    case (state)
      IDLE:    state_n = IDLE;
      LOAD_HI: begin
        state_n   = LOAD_LO;
        loadlow_n = 1'b1;
        half_n    = val_q[HALF_W-1:0];
      end
      LOAD_LO: done_n[idx_q] = 1'b1;
      CLEAR: begin
        done_n[CLR_BIT] = 1'b1;
        state_n         = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Shared accept point: a grant in LOAD_LO chains straight into the next job.
    if (accept) begin
      if (clr_valid) begin
        state_n = CLEAR;
        clr_n   = 1'b0;
      end else if (|grant) begin
        state_n    = LOAD_HI;
        loadhigh_n = 1'b1;
        half_n     = sel_val[VW-1:HALF_W];
        val_n      = sel_val;
        idx_n      = gidx;
        ptr_n      = arb_next;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      idx_q       <= '0;
      val_q       <= '0;
      loadhigh    <= 1'b0;
      loadlow     <= 1'b0;
      halfvaluein <= '0;
      clr_q       <= 1'b1;
      done        <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      idx_q       <= idx_n;
      val_q       <= val_n;
      loadhigh    <= loadhigh_n;
      loadlow     <= loadlow_n;
      halfvaluein <= half_n;
      clr_q       <= clr_n;
      done        <= done_n;
    end
  end

endmodule
